// File: rtl/sentinel_scan_engine.sv
// Sentinel scan engine: sequentially reads a word buffer and stops at the first word equal to a sentinel.
// Optional build macro SENTINEL_MASK_EN adds a cfg_mask port and masked compare.
module sentinel_scan_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_len,
    input  logic [DATA_W-1:0] cfg_sentinel,
`ifdef SENTINEL_MASK_EN
    input  logic [DATA_W-1:0] cfg_mask,
`endif
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              busy,
    output logic              done,
    output logic              irq_req,
    output logic              res_found,
    output logic [ADDR_W-1:0] res_index,
    output logic [ADDR_W-1:0] res_count
);

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FIN = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, len_q, len_d;
    logic [DATA_W-1:0] sent_q, sent_d;
    logic [ADDR_W-1:0] issue_q, issue_d, off_q, off_d, cmp_cnt_q, cmp_cnt_d;
    logic              vld_q, vld_d, abort_q, abort_d;
    logic              res_found_q, res_found_d;
    logic [ADDR_W-1:0] res_index_q, res_index_d, res_count_q, res_count_d;
    logic              scan, issue_ok, cmp, word_eq, hit, last, drained, finish;

`ifdef SENTINEL_MASK_EN
    logic [DATA_W-1:0] mask_q, mask_d;
    assign word_eq = (mem_rd_data & mask_q) == (sent_q & mask_q);
`else
    assign word_eq = mem_rd_data == sent_q;
`endif

    // abort_q marks the cycle after a sampled abort: nothing issues and the in-flight word is dropped.
    // A zero-length scan drains through one SCAN cycle with nothing issued, giving done in cycle 2.
    always_comb begin
        scan     = state_q == SCAN;
        issue_ok = scan && !abort_q && (issue_q != len_q);
        cmp      = scan && vld_q && !abort_q;
        hit      = cmp && word_eq;
        last     = cmp && (off_q == len_q - 1'b1);
        drained  = scan && !vld_q && (issue_q == len_q);
        finish   = scan && (abort_q || hit || last || drained);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            sent_q      <= '0;
            issue_q     <= '0;
            off_q       <= '0;
            cmp_cnt_q   <= '0;
            vld_q       <= 1'b0;
            abort_q     <= 1'b0;
            res_found_q <= 1'b0;
            res_index_q <= '0;
            res_count_q <= '0;
`ifdef SENTINEL_MASK_EN
            mask_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            sent_q      <= sent_d;
            issue_q     <= issue_d;
            off_q       <= off_d;
            cmp_cnt_q   <= cmp_cnt_d;
            vld_q       <= vld_d;
            abort_q     <= abort_d;
            res_found_q <= res_found_d;
            res_index_q <= res_index_d;
            res_count_q <= res_count_d;
`ifdef SENTINEL_MASK_EN
            mask_q      <= mask_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (finish) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        base_d      = base_q;
        len_d       = len_q;
        sent_d      = sent_q;
        issue_d     = issue_q;
        off_d       = issue_q;
        cmp_cnt_d   = cmp_cnt_q;
        vld_d       = issue_ok && !finish;
        abort_d     = scan && !finish && abort;
        res_found_d = res_found_q;
        res_index_d = res_index_q;
        res_count_d = res_count_q;
`ifdef SENTINEL_MASK_EN
        mask_d      = mask_q;
`endif
        if (state_q == IDLE && start) begin
            base_d      = cfg_base;
            len_d       = cfg_len;
            sent_d      = cfg_sentinel;
            issue_d     = '0;
            cmp_cnt_d   = '0;
            res_found_d = 1'b0;
            res_index_d = '0;
            res_count_d = '0;
`ifdef SENTINEL_MASK_EN
            mask_d      = cfg_mask;
`endif
        end
        if (issue_ok) issue_d = issue_q + 1'b1;
        if (cmp) cmp_cnt_d = cmp_cnt_q + 1'b1;
        if (finish) begin
            res_found_d = 1'b0;
            res_index_d = '0;
            if (abort_q) begin
                res_count_d = cmp_cnt_q;
            end else if (hit) begin
                res_found_d = 1'b1;
                res_index_d = off_q;
                res_count_d = off_q + 1'b1;
            end else begin
                res_count_d = len_q;
            end
        end
    end

    always_comb begin
        busy        = scan;
        done        = state_q == FIN;
        irq_req     = state_q == FIN;
        mem_rd_en   = issue_ok;
        mem_rd_addr = issue_ok ? base_q + issue_q : '0;
        res_found   = res_found_q;
        res_index   = res_index_q;
        res_count   = res_count_q;
    end

endmodule

// File: tb/tb_sentinel_scan_engine.sv
// Bench for sentinel_scan_engine: directed and random scans against a timing/result model.
module tb_sentinel_scan_engine;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [9:0]  cfg_base = '0;
    logic [9:0]  cfg_len = '0;
    logic [31:0] cfg_sentinel = '0;
`ifdef SENTINEL_MASK_EN
    logic [31:0] cfg_mask = '0;
`endif
    logic        mem_rd_en;
    logic [9:0]  mem_rd_addr;
    logic [31:0] mem_rd_data = '0;
    logic        busy, done, irq_req, res_found;
    logic [9:0]  res_index, res_count;

    logic [31:0] mem [0:1023];
    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    sentinel_scan_engine #(.DATA_W(32), .ADDR_W(10)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .abort(abort),
        .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_sentinel(cfg_sentinel),
`ifdef SENTINEL_MASK_EN
        .cfg_mask(cfg_mask),
`endif
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .busy(busy), .done(done), .irq_req(irq_req),
        .res_found(res_found), .res_index(res_index), .res_count(res_count)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result and timing follow from the first matching offset and the abort cycle.
    task automatic model(input logic [9:0] base, input logic [9:0] len, input logic [31:0] sent,
                         input logic [31:0] emask, input int ab, output bit f,
                         output logic [9:0] idx, output logic [9:0] cnt, output int d, output int nrd);
        f = 0; idx = '0; cnt = len; d = int'(len) + 2;
        for (int i = 0; i < int'(len); i++) begin
            if ((mem[10'(int'(base) + i)] & emask) == (sent & emask)) begin
                f = 1; idx = 10'(i); cnt = 10'(i + 1); d = i + 3;
                break;
            end
        end
        if (ab >= 1 && ab <= d - 2) begin
            f = 0; idx = '0; cnt = 10'(ab - 1); d = ab + 2;
            nrd = (ab < int'(len)) ? ab : int'(len);
        end else begin
            nrd = (int'(len) < d - 1) ? int'(len) : d - 1;
        end
    endtask

    task automatic run_scan(input string tag, input logic [9:0] base, input logic [9:0] len,
                            input logic [31:0] sent, input logic [31:0] mask, input int ab, input int st2);
        bit ef;
        logic [9:0] eidx, ecnt;
        logic [31:0] emask;
        logic [20:0] clr, at_done, at_hold;
        int ed, enrd, nrd, done_cyc, ndone, busy_err, irq_err, addr_err;
`ifdef SENTINEL_MASK_EN
        emask = mask;
`else
        emask = '1;
`endif
        model(base, len, sent, emask, ab, ef, eidx, ecnt, ed, enrd);
        nrd = 0; done_cyc = -1; ndone = 0; busy_err = 0; irq_err = 0; addr_err = 0;
        clr = '1; at_done = '0; at_hold = '0;
        @(negedge ACLK);
        cfg_base = base; cfg_len = len; cfg_sentinel = sent;
`ifdef SENTINEL_MASK_EN
        cfg_mask = mask;
`endif
        start = 1'b1;
        abort = (ab == 0);
        for (int c = 1; c <= ed + 1; c++) begin
            @(negedge ACLK);
            start = 1'b0;
            abort = 1'b0;
            if (mem_rd_en === 1'b1) begin
                if (mem_rd_addr !== 10'(int'(base) + nrd)) addr_err++;
                nrd++;
            end
            if (busy !== (c < ed)) busy_err++;
            if (irq_req !== done) irq_err++;
            if (done === 1'b1) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c == 1) clr = {res_found, res_index, res_count};
            if (c == ed) at_done = {res_found, res_index, res_count};
            if (c == ed + 1) at_hold = {res_found, res_index, res_count};
            if (c == ab) abort = 1'b1;
            if (c == st2) begin
                start = 1'b1;
                cfg_base = 10'($urandom); cfg_len = 10'($urandom); cfg_sentinel = $urandom;
            end
        end
        abort = 1'b0;
        chk({tag, ".done_cycle"}, done_cyc, ed);
        chk({tag, ".done_pulses"}, ndone, 1);
        chk({tag, ".reads"}, nrd, enrd);
        chk({tag, ".addr_err"}, addr_err, 0);
        chk({tag, ".busy_err"}, busy_err, 0);
        chk({tag, ".irq_err"}, irq_err, 0);
        chk({tag, ".cleared"}, 32'(clr), 0);
        chk({tag, ".found"}, 32'(at_done[20]), 32'(ef));
        chk({tag, ".index"}, 32'(at_done[19:10]), 32'(eidx));
        chk({tag, ".count"}, 32'(at_done[9:0]), 32'(ecnt));
        chk({tag, ".hold"}, 32'(at_hold), 32'(at_done));
    endtask

    initial begin
        int ndone_rst;
        logic [9:0] b, l;
        logic [31:0] s, m;
        int ab, st2;
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i);

        repeat (3) @(negedge ACLK);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.irq", 32'(irq_req), 0);
        chk("rst.rd_en", 32'(mem_rd_en), 0);
        chk("rst.rd_addr", 32'(mem_rd_addr), 0);
        chk("rst.results", {11'b0, res_found, res_index, res_count}, 0);
        ARESET = 1'b0;

        run_scan("match", 10'h010, 10'd8, 32'h14, '1, -1, -1);
        run_scan("nomatch", 10'h010, 10'd8, 32'hDEAD, '1, -1, -1);
        run_scan("wrap", 10'h3FE, 10'd4, 32'h1, '1, -1, -1);
        run_scan("len0", 10'h010, 10'd0, 32'h10, '1, -1, -1);
        run_scan("abort", 10'h010, 10'd8, 32'hDEAD, '1, 4, 3);
        run_scan("start_wins", 10'h010, 10'd8, 32'h12, '1, 0, -1);
        mem[2] = 32'hABCD1234;
        run_scan("mask", 10'h000, 10'd8, 32'hABCD0000, 32'hFFFF0000, -1, -1);

        @(negedge ACLK);
        cfg_base = 10'h010; cfg_len = 10'd8; cfg_sentinel = 32'hDEAD; start = 1'b1;
        @(negedge ACLK); start = 1'b0;
        @(negedge ACLK);
        @(negedge ACLK); ARESET = 1'b1;
        @(negedge ACLK); ARESET = 1'b0;
        chk("midrst.busy", 32'(busy), 0);
        chk("midrst.done", 32'(done), 0);
        chk("midrst.rd_en", 32'(mem_rd_en), 0);
        chk("midrst.results", {11'b0, res_found, res_index, res_count}, 0);
        ndone_rst = 0;
        repeat (12) begin
            @(negedge ACLK);
            if (done !== 1'b0 || busy !== 1'b0) ndone_rst++;
        end
        chk("midrst.quiet", ndone_rst, 0);
        run_scan("after_rst", 10'h020, 10'd6, 32'h23, '1, -1, -1);

        for (int i = 0; i < 1024; i++) mem[i] = $urandom_range(0, 63);
        for (int r = 0; r < 25; r++) begin
            b = 10'($urandom);
            l = 10'($urandom_range(0, 12));
            if ($urandom_range(0, 1) == 1 && l != 0) s = mem[10'(int'(b) + int'($urandom_range(0, int'(l) - 1)))];
            else s = $urandom_range(0, 80);
            m = ($urandom_range(0, 3) == 0) ? $urandom : '1;
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, int'(l) + 3)) : -1;
            st2 = ($urandom_range(0, 1) == 1) ? 1 : -1;
            run_scan("rand", b, l, s, m, ab, st2);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
